mul_graph_launcher: RTL and testbench

Upstream launch stage for the dynamically scheduled `mul_graph` dataflow block. It accepts operand triples (a, b, c) from a host valid/ready stream and registers them. It then drives them into the graph's start/argument ports with a start token, holding them stable until the token is accepted. It bounds the number of in-flight launches and returns the graph's `end_out` results to the host through a one-entry output register.

---
 rtl/mul_graph_launcher_if.sv | 59 +++++
 rtl/mul_graph_launcher.sv | 149 ++++++++++++++
 tb/tb_mul_graph_launcher.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_graph_launcher_if.sv
// Handshake bundle between the mul_graph launcher, its host stream and the graph ports.
// The launcher connects through the master modport; the host/graph side uses slave.
interface mul_graph_launcher_if #(
    parameter int unsigned DATA_W = 32
);
    logic              host_valid;
    logic              host_ready;
    logic [DATA_W-1:0] host_a;
    logic [DATA_W-1:0] host_b;
    logic [DATA_W-1:0] host_c;

    logic              start_in;
    logic              start_valid;
    logic              start_ready;

    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] c_din;
    logic              a_valid_in;
    logic              b_valid_in;
    logic              c_valid_in;
    logic              a_ready_out;
    logic              b_ready_out;
    logic              c_ready_out;

    logic [DATA_W-1:0] end_out;
    logic              end_valid;
    logic              end_ready;

    logic [DATA_W-1:0] res_out;
    logic              res_valid;
    logic              res_ready;

    modport master (
        input  host_valid, host_a, host_b, host_c,
        output host_ready,
        output start_in, start_valid,
        input  start_ready,
        output a_din, b_din, c_din, a_valid_in, b_valid_in, c_valid_in,
        input  a_ready_out, b_ready_out, c_ready_out,
        input  end_out, end_valid,
        output end_ready,
        output res_out, res_valid,
        input  res_ready
    );

    modport slave (
        output host_valid, host_a, host_b, host_c,
        input  host_ready,
        input  start_in, start_valid,
        output start_ready,
        input  a_din, b_din, c_din, a_valid_in, b_valid_in, c_valid_in,
        output a_ready_out, b_ready_out, c_ready_out,
        output end_out, end_valid,
        input  end_ready,
        input  res_out, res_valid,
        output res_ready
    );
endinterface

// File: rtl/mul_graph_launcher.sv
// Launch stage for mul_graph: registers host operand triples, issues start tokens, bounds
// in-flight launches and buffers results. MUL_GRAPH_LAUNCHER_STATS_EN adds launch/done counters.
module mul_graph_launcher #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_graph_launcher_if.master  bus,
    output logic [3:0]            inflight,
    output logic                  err_spurious
`ifdef MUL_GRAPH_LAUNCHER_STATS_EN
    ,
    output logic [31:0]           launch_cnt,
    output logic [31:0]           done_cnt
`endif
);
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic host_ready_c;
    logic accept_c;
    logic launch_c;
    logic end_ready_c;
    logic done_c;
    logic spurious_c;
    logic dec_c;
    logic unused_ready_c;

    // Graph-side ready on the argument ports carries no information beyond start_ready.
    assign unused_ready_c = &{1'b1, bus.a_ready_out, bus.b_ready_out, bus.c_ready_out};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        host_ready_c    = 1'b0;
        accept_c        = 1'b0;
        launch_c        = 1'b0;
        bus.start_valid = 1'b0;
        bus.start_in    = 1'b0;
        case (state_q)
            IDLE: begin
                host_ready_c = (inflight < MAX_CNT);
                accept_c     = bus.host_valid && host_ready_c;
                if (accept_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.start_valid = 1'b1;
                bus.start_in    = 1'b1;
                if (bus.start_ready) begin
                    launch_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.host_ready = host_ready_c;
    assign bus.a_valid_in = bus.start_valid;
    assign bus.b_valid_in = bus.start_valid;
    assign bus.c_valid_in = bus.start_valid;

    // Operands only load in IDLE, so they stay frozen for the whole ISSUE phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a_din <= '0;
            bus.b_din <= '0;
            bus.c_din <= '0;
        end else if (accept_c) begin
            bus.a_din <= bus.host_a;
            bus.b_din <= bus.host_b;
            bus.c_din <= bus.host_c;
        end
    end

    assign end_ready_c   = !bus.res_valid || bus.res_ready;
    assign bus.end_ready = end_ready_c;
    assign done_c        = bus.end_valid && end_ready_c;
    assign spurious_c    = done_c && (inflight == '0);
    assign dec_c         = done_c && !spurious_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_out   <= '0;
            bus.res_valid <= 1'b0;
        end else if (done_c) begin
            bus.res_out   <= bus.end_out;
            bus.res_valid <= 1'b1;
        end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
        end
    end

    // A completion at zero is flagged but never wraps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({launch_c, dec_c})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_spurious <= 1'b0;
        end else if (spurious_c) begin
            err_spurious <= 1'b1;
        end
    end

`ifdef MUL_GRAPH_LAUNCHER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            launch_cnt <= '0;
            done_cnt   <= '0;
        end else begin
            if (launch_c) begin
                launch_cnt <= launch_cnt + 32'd1;
            end
            if (done_c) begin
                done_cnt <= done_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_graph_launcher.sv
// Directed bench for mul_graph_launcher: stimulus pushes expected launches/results into
// queues that negedge monitors pop on each start and result handshake.
module tb_mul_graph_launcher;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] inflight;
    logic err_spurious;
`ifdef MUL_GRAPH_LAUNCHER_STATS_EN
    logic [31:0] launch_cnt;
    logic [31:0] done_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int launches_seen = 0;
    op_t exp_launch[$];
    logic [31:0] exp_res[$];

    mul_graph_launcher_if #(.DATA_W(DATA_W)) bus ();

    mul_graph_launcher #(.DATA_W(DATA_W), .MAX_INFLIGHT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .inflight(inflight),
        .err_spurious(err_spurious)
`ifdef MUL_GRAPH_LAUNCHER_STATS_EN
        ,
        .launch_cnt(launch_cnt),
        .done_cnt(done_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start-token monitor: every accepted token must carry the next expected operand triple.
    always @(negedge clk) begin
        if (!rst && bus.start_valid && bus.start_ready) begin
            launches_seen++;
            if (exp_launch.size() == 0) begin
                check("unexpected_launch", 32'd1, 32'd0);
            end else begin
                op_t e;
                e = exp_launch.pop_front();
                check("launch_a", bus.a_din, e.a);
                check("launch_b", bus.b_din, e.b);
                check("launch_c", bus.c_din, e.c);
                check("launch_start_in", 32'(bus.start_in), 32'd1);
            end
        end
    end

    // Result monitor: every host-side result handshake pops the expected value in order.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_res.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                check("result", bus.res_out, exp_res.pop_front());
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int n;
        op_t e;
        n = 0;
        while (!bus.host_ready && n < 20) begin
            cyc();
            n++;
        end
        check("launch_host_ready_timeout", 32'(bus.host_ready), 32'd1);
        bus.host_valid = 1'b1;
        bus.host_a = a;
        bus.host_b = b;
        bus.host_c = c;
        e.a = a; e.b = b; e.c = c;
        exp_launch.push_back(e);
        cyc();
        bus.host_valid = 1'b0;
        cyc();
    endtask

    task automatic complete(input logic [31:0] v);
        bus.end_valid = 1'b1;
        bus.end_out = v;
        exp_res.push_back(v);
        cyc();
        bus.end_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t e;
        int base;
        bus.host_valid = 1'b0;
        bus.host_a = '0;
        bus.host_b = '0;
        bus.host_c = '0;
        bus.start_ready = 1'b1;
        bus.a_ready_out = 1'b1;
        bus.b_ready_out = 1'b1;
        bus.c_ready_out = 1'b1;
        bus.end_out = '0;
        bus.end_valid = 1'b0;
        bus.res_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        check("rst_host_ready", 32'(bus.host_ready), 32'd1);
        check("rst_start_valid", 32'(bus.start_valid), 32'd0);
        check("rst_start_in", 32'(bus.start_in), 32'd0);
        check("rst_a_valid_in", 32'(bus.a_valid_in), 32'd0);
        check("rst_a_din", bus.a_din, 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_out", bus.res_out, 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_err", 32'(err_spurious), 32'd0);
        check("rst_end_ready", 32'(bus.end_ready), 32'd1);

        // Single launch 3*5*7 = 105, returned 6 cycles after the token.
        bus.host_valid = 1'b1;
        bus.host_a = 32'd3; bus.host_b = 32'd5; bus.host_c = 32'd7;
        e.a = 32'd3; e.b = 32'd5; e.c = 32'd7;
        exp_launch.push_back(e);
        cyc();
        bus.host_valid = 1'b0;
        check("single_start_valid_hi", 32'(bus.start_valid), 32'd1);
        check("single_b_valid_in", 32'(bus.b_valid_in), 32'd1);
        check("single_host_ready_lo", 32'(bus.host_ready), 32'd0);
        check("single_inflight0", 32'(inflight), 32'd0);
        cyc();
        check("single_start_valid_lo", 32'(bus.start_valid), 32'd0);
        check("single_inflight1", 32'(inflight), 32'd1);
        repeat (5) cyc();
        complete(32'd105);
        check("single_res_valid", 32'(bus.res_valid), 32'd1);
        check("single_res_out", bus.res_out, 32'd105);
        check("single_inflight_back0", 32'(inflight), 32'd0);
        cyc();
        check("single_res_cleared", 32'(bus.res_valid), 32'd0);

        // Start backpressure with a changing host_a: 11*12*13 = 1716.
        bus.start_ready = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_a = 32'd11; bus.host_b = 32'd12; bus.host_c = 32'd13;
        e.a = 32'd11; e.b = 32'd12; e.c = 32'd13;
        exp_launch.push_back(e);
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.host_a = 32'(100 + i);
            cyc();
            check("bp_a_din", bus.a_din, 32'd11);
            check("bp_c_din", bus.c_din, 32'd13);
            check("bp_start_valid", 32'(bus.start_valid), 32'd1);
            check("bp_host_ready", 32'(bus.host_ready), 32'd0);
        end
        bus.host_valid = 1'b0;
        bus.start_ready = 1'b1;
        cyc();
        check("bp_inflight", 32'(inflight), 32'd1);
        complete(32'd1716);
        cyc();

        // In-flight limit: host keeps offering 2,3,4; graph never completes.
        base = launches_seen;
        for (int i = 0; i < 4; i++) begin
            e.a = 32'd2; e.b = 32'd3; e.c = 32'd4;
            exp_launch.push_back(e);
        end
        bus.host_valid = 1'b1;
        bus.host_a = 32'd2; bus.host_b = 32'd3; bus.host_c = 32'd4;
        repeat (14) cyc();
        bus.host_valid = 1'b0;
        check("limit_launches", 32'(launches_seen - base), 32'd4);
        check("limit_inflight", 32'(inflight), 32'd4);
        check("limit_host_ready", 32'(bus.host_ready), 32'd0);
        complete(32'd24);
        check("limit_inflight_dec", 32'(inflight), 32'd3);
        check("limit_host_ready_back", 32'(bus.host_ready), 32'd1);
        complete(32'd24);
        complete(32'd24);
        complete(32'd24);
        check("limit_drained", 32'(inflight), 32'd0);
        cyc();

        // Result backpressure with two results pending.
        launch(32'd1, 32'd2, 32'd3);
        launch(32'd4, 32'd5, 32'd6);
        check("rbp_inflight2", 32'(inflight), 32'd2);
        bus.res_ready = 1'b0;
        bus.end_valid = 1'b1;
        bus.end_out = 32'd6;
        exp_res.push_back(32'd6);
        cyc();
        bus.end_out = 32'd120;
        exp_res.push_back(32'd120);
        check("rbp_res_valid", 32'(bus.res_valid), 32'd1);
        check("rbp_res_out_first", bus.res_out, 32'd6);
        check("rbp_end_ready", 32'(bus.end_ready), 32'd0);
        cyc();
        check("rbp_res_out_held", bus.res_out, 32'd6);
        check("rbp_end_ready_held", 32'(bus.end_ready), 32'd0);
        check("rbp_inflight_pending", 32'(inflight), 32'd1);
        bus.res_ready = 1'b1;
        cyc();
        bus.end_valid = 1'b0;
        check("rbp_res_out_second", bus.res_out, 32'd120);
        check("rbp_res_valid_second", 32'(bus.res_valid), 32'd1);
        check("rbp_inflight0", 32'(inflight), 32'd0);
        cyc();

        // Simultaneous launch and completion at inflight 2.
        launch(32'd7, 32'd8, 32'd9);
        launch(32'd1, 32'd1, 32'd2);
        bus.host_valid = 1'b1;
        bus.host_a = 32'd1; bus.host_b = 32'd1; bus.host_c = 32'd1;
        e.a = 32'd1; e.b = 32'd1; e.c = 32'd1;
        exp_launch.push_back(e);
        cyc();
        bus.host_valid = 1'b0;
        check("sim_in_issue", 32'(bus.start_valid), 32'd1);
        complete(32'd504);
        check("sim_inflight_same", 32'(inflight), 32'd2);
        complete(32'd2);
        complete(32'd1);
        check("sim_drained", 32'(inflight), 32'd0);

        // Spurious completion at inflight 0.
        complete(32'd77);
        check("spur_err", 32'(err_spurious), 32'd1);
        check("spur_inflight", 32'(inflight), 32'd0);
        check("spur_res_out", bus.res_out, 32'd77);
        cyc();

        // Reset while in ISSUE with a held result.
        bus.res_ready = 1'b0;
        bus.start_ready = 1'b0;
        bus.end_valid = 1'b1;
        bus.end_out = 32'd55;
        bus.host_valid = 1'b1;
        bus.host_a = 32'd9; bus.host_b = 32'd9; bus.host_c = 32'd9;
        cyc();
        bus.end_valid = 1'b0;
        bus.host_valid = 1'b0;
        check("pre_rst_start_valid", 32'(bus.start_valid), 32'd1);
        check("pre_rst_res_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_start_valid", 32'(bus.start_valid), 32'd0);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_inflight", 32'(inflight), 32'd0);
        check("mid_rst_host_ready", 32'(bus.host_ready), 32'd1);
        check("mid_rst_err", 32'(err_spurious), 32'd0);
        check("mid_rst_a_din", bus.a_din, 32'd0);
`ifdef MUL_GRAPH_LAUNCHER_STATS_EN
        check("mid_rst_launch_cnt", launch_cnt, 32'd0);
        check("mid_rst_done_cnt", done_cnt, 32'd0);
`endif
        bus.res_ready = 1'b1;
        bus.start_ready = 1'b1;
        repeat (3) cyc();

        check("launch_queue_empty", 32'(exp_launch.size()), 32'd0);
        check("result_queue_empty", 32'(exp_res.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
